// File: rtl/sampler_pkg.sv
// Shared definitions for the sampling interval controller: FSM state
// encoding, default widths and the drop counter width.
package sampler_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEFAULT_LFSR_W       = 9;
    localparam int DEFAULT_MASK_W       = 8;
    localparam int DEFAULT_MIN_INTERVAL = 16;
    localparam int DEFAULT_CNT_W        = 10;
    localparam int DEFAULT_TAG_W        = 32;
    localparam int DROP_CNT_W           = 16;

endpackage

// File: rtl/interval_down_counter.sv
// Loadable down counter holding the number of references left in the
// current sampling interval. The expiry flag marks the decrement that
// consumes the last reference of the interval.
module interval_down_counter #(
    parameter int CNT_W = 10
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_value_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             expire_o
);

    logic [CNT_W-1:0] r_count;

    // Load has priority over decrement; the count never wraps below zero.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_count <= '0;
        end else if (load_i) begin
            r_count <= load_value_i;
        end else if (dec_i && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign count_o  = r_count;
    assign expire_o = dec_i && (r_count == CNT_W'(1));

endmodule

// File: rtl/sampling_interval_controller.sv
// Turns the cache LFSR output into randomly spaced sampling decisions on
// the reference stream and offers each sampled tag downstream over a
// valid/ready handshake. One LFSR value is consumed per interval.
// Optional build macro: SAMPLER_DROP_COUNT_EN adds a saturating counter
// of references ignored outside counting; without it drop_count_o is 0.
module sampling_interval_controller
    import sampler_pkg::*;
#(
    parameter int LFSR_W       = DEFAULT_LFSR_W,
    parameter int MASK_W       = DEFAULT_MASK_W,
    parameter int MIN_INTERVAL = DEFAULT_MIN_INTERVAL,
    parameter int CNT_W        = DEFAULT_CNT_W,
    parameter int TAG_W        = DEFAULT_TAG_W
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  enable_i,
    input  logic                  ref_valid_i,
    input  logic [TAG_W-1:0]      ref_tag_i,
    input  logic [LFSR_W-1:0]     lfsr_value_i,
    output logic                  lfsr_enable_o,
    output logic                  sample_valid_o,
    input  logic                  sample_ready_i,
    output logic [TAG_W-1:0]      sample_tag_o,
    output logic [CNT_W-1:0]      interval_o,
    output logic [DROP_CNT_W-1:0] drop_count_o
);

    state_t           r_state;
    state_t           w_nextState;
    logic             r_sampleValid;
    logic [TAG_W-1:0] r_sampleTag;
    logic             w_load;
    logic             w_dec;
    logic             w_capture;
    logic             w_release;
    logic             w_lfsrEnable;
    logic             w_expire;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_loadValue;

    // Interval length is the fixed minimum plus the masked random bits.
    assign w_loadValue = CNT_W'(MIN_INTERVAL) + CNT_W'(lfsr_value_i[MASK_W-1:0]);

    generate
        if (MASK_W < LFSR_W) begin : g_unusedLfsr
            logic w_unusedLfsrBits;
            assign w_unusedLfsrBits = ^lfsr_value_i[LFSR_W-1:MASK_W];
        end
    endgenerate

    interval_down_counter #(
        .CNT_W(CNT_W)
    ) u_intervalCounter (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .load_i      (w_load),
        .load_value_i(w_loadValue),
        .dec_i       (w_dec),
        .count_o     (w_count),
        .expire_o    (w_expire)
    );

    // State register; reset always returns to LOAD.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode plus the per-state counter and sample controls.
    always_comb begin
        w_nextState  = r_state;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        w_capture    = 1'b0;
        w_release    = 1'b0;
        w_lfsrEnable = 1'b0;
        case (r_state)
            LOAD: begin
                w_load       = 1'b1;
                w_lfsrEnable = !reset_i;
                w_nextState  = COUNT;
            end
            COUNT: begin
                if (enable_i && ref_valid_i) begin
                    w_dec = 1'b1;
                    if (w_expire) begin
                        w_capture   = 1'b1;
                        w_nextState = HOLD;
                    end
                end
            end
            HOLD: begin
                if (r_sampleValid && sample_ready_i) begin
                    w_release   = 1'b1;
                    w_nextState = LOAD;
                end
            end
            default: begin
                w_nextState = LOAD;
            end
        endcase
    end

    // Sample register: capture on expiry, hold until the downstream accepts.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_sampleValid <= 1'b0;
            r_sampleTag   <= '0;
        end else if (w_capture) begin
            r_sampleValid <= 1'b1;
            r_sampleTag   <= ref_tag_i;
        end else if (w_release) begin
            r_sampleValid <= 1'b0;
        end
    end

    assign lfsr_enable_o  = w_lfsrEnable;
    assign sample_valid_o = r_sampleValid;
    assign sample_tag_o   = r_sampleTag;
    assign interval_o     = w_count;

`ifdef SAMPLER_DROP_COUNT_EN
    logic                  w_drop;
    logic [DROP_CNT_W-1:0] r_dropCount;

    assign w_drop = ref_valid_i && !((r_state == COUNT) && enable_i);

    // Saturating count of references that arrive while not counting.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_dropCount <= '0;
        end else if (w_drop && (r_dropCount != '1)) begin
            r_dropCount <= r_dropCount + DROP_CNT_W'(1);
        end
    end

    assign drop_count_o = r_dropCount;
`else
    assign drop_count_o = '0;
`endif

endmodule

// File: tb/tb_sampling_interval_controller.sv
// Self-checking bench for sampling_interval_controller. Expected sample
// tags are queued when the triggering reference is driven and compared
// when the DUT offers the sample on its handshake.
module tb_sampling_interval_controller;

    localparam int TAG_W  = 32;
    localparam int CNT_W  = 10;
    localparam int LFSR_W = 9;

    logic              clock_i;
    logic              reset_i;
    logic              enable_i;
    logic              ref_valid_i;
    logic [TAG_W-1:0]  ref_tag_i;
    logic [LFSR_W-1:0] lfsr_value_i;
    logic              lfsr_enable_o;
    logic              sample_valid_o;
    logic              sample_ready_i;
    logic [TAG_W-1:0]  sample_tag_o;
    logic [CNT_W-1:0]  interval_o;
    logic [15:0]       drop_count_o;

    int assertCount = 0;
    int failCount   = 0;
    int lfsrPulses  = 0;
    int expDrop     = 0;
    logic [TAG_W-1:0] scoreboard[$];

    sampling_interval_controller dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .enable_i      (enable_i),
        .ref_valid_i   (ref_valid_i),
        .ref_tag_i     (ref_tag_i),
        .lfsr_value_i  (lfsr_value_i),
        .lfsr_enable_o (lfsr_enable_o),
        .sample_valid_o(sample_valid_o),
        .sample_ready_i(sample_ready_i),
        .sample_tag_o  (sample_tag_o),
        .interval_o    (interval_o),
        .drop_count_o  (drop_count_o)
    );

    // Free-running clock, period 10.
    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    // Count LFSR advance pulses mid-cycle, away from the active edge.
    always @(negedge clock_i) begin
        if (lfsr_enable_o === 1'b1) lfsrPulses++;
    end

    // Hard bound on simulation time.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] dropExpected();
`ifdef SAMPLER_DROP_COUNT_EN
        return 16'(expDrop);
`else
        return 16'd0;
`endif
    endfunction

    // Drive one cycle of inputs and return 1 time unit after the rising edge.
    task automatic applyStimulus(input logic rst, input logic en, input logic refv,
                                 input logic [TAG_W-1:0] tag, input logic [LFSR_W-1:0] lfsrv,
                                 input logic rdy);
        reset_i        = rst;
        enable_i       = en;
        ref_valid_i    = refv;
        ref_tag_i      = tag;
        lfsr_value_i   = lfsrv;
        sample_ready_i = rdy;
        @(posedge clock_i);
        #1;
    endtask

    // Reset state of every output.
    task automatic test_reset();
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h55, 9'h011, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h66, 9'h011, 1'b0);
        assertCount++;
        if (sample_valid_o !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid: got %0b expected 0", sample_valid_o); end
        assertCount++;
        if (sample_tag_o !== 32'd0) begin failCount++; $display("[TB] FAIL reset_tag: got %0d expected 0", sample_tag_o); end
        assertCount++;
        if (interval_o !== 10'd0) begin failCount++; $display("[TB] FAIL reset_interval: got %0d expected 0", interval_o); end
        assertCount++;
        if (drop_count_o !== 16'd0) begin failCount++; $display("[TB] FAIL reset_drop: got %0d expected 0", drop_count_o); end
        assertCount++;
        if (lfsr_enable_o !== 1'b0) begin failCount++; $display("[TB] FAIL reset_lfsr_en: got %0b expected 0", lfsr_enable_o); end
    endtask

    // One full interval starting in LOAD: optional enable gap, optional backpressure.
    task automatic test_interval(input logic [LFSR_W-1:0] lfsrv, input int expN,
                                 input int tagBase, input int holdCycles,
                                 input int gapAt, input int gapLen);
        int p0;
        int n;
        p0 = lfsrPulses;
        applyStimulus(1'b0, 1'b1, 1'b0, '0, lfsrv, 1'b0);
        assertCount++;
        if (interval_o !== 10'(expN)) begin failCount++; $display("[TB] FAIL load_interval: got %0d expected %0d", interval_o, expN); end
        assertCount++;
        if (lfsrPulses != p0 + 1) begin failCount++; $display("[TB] FAIL load_pulse: got %0d expected %0d", lfsrPulses - p0, 1); end
        scoreboard.push_back(32'(tagBase + expN));
        n = 0;
        while (sample_valid_o !== 1'b1 && n < expN + 4) begin
            n++;
            applyStimulus(1'b0, 1'b1, 1'b1, 32'(tagBase + n), lfsrv, 1'b0);
            if (gapAt != 0 && n == gapAt) begin
                for (int i = 0; i < gapLen; i++) begin
                    applyStimulus(1'b0, 1'b0, 1'b1, 32'hDEAD_0000 + 32'(i), lfsrv, 1'b0);
                    expDrop++;
                    assertCount++;
                    if (interval_o !== 10'(expN - gapAt)) begin failCount++; $display("[TB] FAIL gap_interval: got %0d expected %0d", interval_o, expN - gapAt); end
                    assertCount++;
                    if (sample_valid_o !== 1'b0) begin failCount++; $display("[TB] FAIL gap_early_sample: got %0b expected 0", sample_valid_o); end
                end
            end
        end
        assertCount++;
        if (n != expN) begin failCount++; $display("[TB] FAIL refs_to_sample: got %0d expected %0d", n, expN); end
        assertCount++;
        if (interval_o !== 10'd0) begin failCount++; $display("[TB] FAIL expired_interval: got %0d expected 0", interval_o); end
        for (int i = 0; i < holdCycles; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 32'(tagBase + 500 + i), lfsrv, 1'b0);
            expDrop++;
            assertCount++;
            if (sample_valid_o !== 1'b1) begin failCount++; $display("[TB] FAIL hold_valid: got %0b expected 1", sample_valid_o); end
            assertCount++;
            if (sample_tag_o !== 32'(tagBase + expN)) begin failCount++; $display("[TB] FAIL hold_tag: got %0d expected %0d", sample_tag_o, tagBase + expN); end
        end
        assertCount++;
        if (drop_count_o !== dropExpected()) begin failCount++; $display("[TB] FAIL drop_count: got %0d expected %0d", drop_count_o, dropExpected()); end
        assertCount++;
        if (sample_valid_o !== 1'b1) begin failCount++; $display("[TB] FAIL offer_valid: got %0b expected 1", sample_valid_o); end
        if (scoreboard.size() > 0) begin
            logic [TAG_W-1:0] expTag;
            expTag = scoreboard.pop_front();
            assertCount++;
            if (sample_tag_o !== expTag) begin failCount++; $display("[TB] FAIL sample_tag: got %0d expected %0d", sample_tag_o, expTag); end
        end
        applyStimulus(1'b0, 1'b1, 1'b0, '0, lfsrv, 1'b1);
        assertCount++;
        if (sample_valid_o !== 1'b0) begin failCount++; $display("[TB] FAIL handshake_clear: got %0b expected 0", sample_valid_o); end
        assertCount++;
        if (lfsr_enable_o !== 1'b1) begin failCount++; $display("[TB] FAIL reload_pulse: got %0b expected 1", lfsr_enable_o); end
        assertCount++;
        if (lfsrPulses != p0 + 1) begin failCount++; $display("[TB] FAIL pulses_per_interval: got %0d expected %0d", lfsrPulses - p0, 1); end
    endtask

    // Reset while a sample is pending discards it and restarts in LOAD.
    task automatic test_reset_in_hold();
        int n;
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 9'h002, 1'b0);
        scoreboard.push_back(32'd7018);
        n = 0;
        while (sample_valid_o !== 1'b1 && n < 30) begin
            n++;
            applyStimulus(1'b0, 1'b1, 1'b1, 32'(7000 + n), 9'h002, 1'b0);
        end
        assertCount++;
        if (n != 18) begin failCount++; $display("[TB] FAIL rst_refs_to_sample: got %0d expected 18", n); end
        assertCount++;
        if (sample_tag_o !== scoreboard[0]) begin failCount++; $display("[TB] FAIL rst_pending_tag: got %0d expected %0d", sample_tag_o, scoreboard[0]); end
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h77, 9'h002, 1'b0);
        void'(scoreboard.pop_front());
        expDrop = 0;
        assertCount++;
        if (sample_valid_o !== 1'b0) begin failCount++; $display("[TB] FAIL rst_hold_valid: got %0b expected 0", sample_valid_o); end
        assertCount++;
        if (sample_tag_o !== 32'd0) begin failCount++; $display("[TB] FAIL rst_hold_tag: got %0d expected 0", sample_tag_o); end
        assertCount++;
        if (interval_o !== 10'd0) begin failCount++; $display("[TB] FAIL rst_hold_interval: got %0d expected 0", interval_o); end
        assertCount++;
        if (drop_count_o !== 16'd0) begin failCount++; $display("[TB] FAIL rst_hold_drop: got %0d expected 0", drop_count_o); end
        reset_i = 1'b0;
        #1;
        assertCount++;
        if (lfsr_enable_o !== 1'b1) begin failCount++; $display("[TB] FAIL rst_load_pulse: got %0b expected 1", lfsr_enable_o); end
    endtask

    // Continuous references with ready held high and random LFSR values.
    task automatic test_back_to_back();
        int phase;
        int rem;
        int n;
        int p0;
        int numLoads;
        int numSamples;
        logic [LFSR_W-1:0] lf;
        logic [TAG_W-1:0]  tag;
        logic [TAG_W-1:0]  expTag;
        phase = 0;
        rem = 0;
        n = 0;
        numLoads = 0;
        numSamples = 0;
        lf = '0;
        p0 = lfsrPulses;
        for (int cyc = 0; cyc < 300; cyc++) begin
            tag = 32'(20000 + cyc);
            if (phase == 0) begin
                lf = 9'($urandom_range(0, 511));
                n = 16 + int'(lf[7:0]);
                assertCount++;
                if (lfsr_enable_o !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_load_pulse: got %0b expected 1", lfsr_enable_o); end
                applyStimulus(1'b0, 1'b1, 1'b1, tag, lf, 1'b1);
                expDrop++;
                numLoads++;
                assertCount++;
                if (interval_o !== 10'(n)) begin failCount++; $display("[TB] FAIL b2b_interval: got %0d expected %0d", interval_o, n); end
                rem = n;
                phase = 1;
            end else if (phase == 1) begin
                assertCount++;
                if (lfsr_enable_o !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_count_pulse: got %0b expected 0", lfsr_enable_o); end
                applyStimulus(1'b0, 1'b1, 1'b1, tag, lf, 1'b1);
                rem--;
                assertCount++;
                if (interval_o !== 10'(rem)) begin failCount++; $display("[TB] FAIL b2b_remaining: got %0d expected %0d", interval_o, rem); end
                if (rem == 0) begin
                    scoreboard.push_back(tag);
                    phase = 2;
                end
                assertCount++;
                if (sample_valid_o !== (rem == 0)) begin failCount++; $display("[TB] FAIL b2b_valid: got %0b expected %0b", sample_valid_o, rem == 0); end
            end else begin
                assertCount++;
                if (sample_valid_o !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_hold_valid: got %0b expected 1", sample_valid_o); end
                expTag = scoreboard.pop_front();
                assertCount++;
                if (sample_tag_o !== expTag) begin failCount++; $display("[TB] FAIL b2b_tag: got %0d expected %0d", sample_tag_o, expTag); end
                numSamples++;
                applyStimulus(1'b0, 1'b1, 1'b1, tag, lf, 1'b1);
                expDrop++;
                assertCount++;
                if (sample_valid_o !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_clear: got %0b expected 0", sample_valid_o); end
                phase = 0;
            end
        end
        assertCount++;
        if (lfsrPulses - p0 != numLoads) begin failCount++; $display("[TB] FAIL b2b_pulse_total: got %0d expected %0d", lfsrPulses - p0, numLoads); end
        assertCount++;
        if (numSamples < 1) begin failCount++; $display("[TB] FAIL b2b_samples: got %0d expected at least 1", numSamples); end
        assertCount++;
        if (drop_count_o !== dropExpected()) begin failCount++; $display("[TB] FAIL b2b_drop: got %0d expected %0d", drop_count_o, dropExpected()); end
    endtask

    // Test sequence.
    initial begin
        reset_i        = 1'b1;
        enable_i       = 1'b0;
        ref_valid_i    = 1'b0;
        ref_tag_i      = '0;
        lfsr_value_i   = '0;
        sample_ready_i = 1'b0;
        $display("[TB] starting sampling_interval_controller bench");
        test_reset();
        test_interval(9'h011, 33, 0, 10, 0, 0);
        test_interval(9'h1FF, 271, 1000, 0, 0, 0);
        test_interval(9'h100, 16, 2000, 2, 0, 0);
        test_interval(9'h004, 20, 3000, 0, 8, 5);
        test_reset_in_hold();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
